crossp_sched: RTL

- Shares one pipelined 3-vector cross-product unit among NREQ requesters.
- Grants at most one operand pair per cycle using round-robin arbitration, gated by per-requester credits.
- Carries the requester ID through a tag pipe that matches the unit's latency, and steers each result back to its owner.
- Sits between the matrix-engine clients and the crossp datapath instance.

---
 rtl/crossp_sched_pkg.sv | 19 +
 rtl/crossp_sched_delay_pipe.sv | 28 ++
 rtl/crossp_sched_rr_arb.sv | 30 +++
 rtl/crossp_sched.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/crossp_sched_pkg.sv
// Shared fixed-point cross-product definitions used by the crossp scheduler.
// Holds the crossp latency, the 3-vector payload type and the ID-width rule.
package crossp_sched_pkg;

    localparam int unsigned CROSSP_LAT = 4;
    localparam int unsigned FP_WIDTH   = 32;

    typedef struct packed {
        logic signed [FP_WIDTH-1:0] z;
        logic signed [FP_WIDTH-1:0] y;
        logic signed [FP_WIDTH-1:0] x;
    } vec3_t;

    // Requester ID width: clog2(n), never less than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/crossp_sched_delay_pipe.sv
// Generic fixed-latency delay pipe with synchronous active-low flush.
module delay_pipe #(
    parameter int unsigned DELAY = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DELAY*WIDTH-1:0] r_sr;

    if (DELAY == 1) begin : g_single
        always_ff @(posedge clk) begin
            if (!reset_l) r_sr <= '0;
            else          r_sr <= i_d;
        end
    end else begin : g_multi
        always_ff @(posedge clk) begin
            if (!reset_l) r_sr <= '0;
            else          r_sr <= {r_sr[(DELAY-1)*WIDTH-1:0], i_d};
        end
    end

    assign o_q = r_sr[DELAY*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/crossp_sched_rr_arb.sv
// Combinational round-robin arbiter: scan starts one past the pointer,
// and the first eligible requester receives a one-hot grant.
module rr_arb
    import crossp_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant
);

    logic [IDW-1:0] w_idx;
    logic           w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((32'(i_ptr) + k) % NREQ);
            if (!w_found && i_elig[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crossp_sched.sv
// Shares one pipelined cross-product unit among NREQ requesters using
// credit-gated round-robin issue and tag-steered result return.
module crossp_sched
    import crossp_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LAT     = CROSSP_LAT,
    parameter int unsigned MAXCRED = 2
) (
    input  logic                    clk,
    input  logic                    reset_l,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*3*WIDTH-1:0] req_a,
    input  logic [NREQ*3*WIDTH-1:0] req_b,
    output logic                    cp_valid,
    output logic [3*WIDTH-1:0]      cp_a,
    output logic [3*WIDTH-1:0]      cp_b,
    input  logic [3*WIDTH-1:0]      cp_o,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [3*WIDTH-1:0]      rsp_data,
    input  logic [NREQ-1:0]         credit_ret,
    output logic                    cred_err
);

    localparam int unsigned VW  = 3 * WIDTH;
    localparam int unsigned IDW = id_width(NREQ);
    localparam int unsigned CW  = $clog2(MAXCRED + 1);
    localparam int unsigned TW  = 1 + IDW;

    logic [NREQ-1:0] w_elig;
    logic [NREQ-1:0] w_grant;
    logic [NREQ-1:0] w_acc;
    logic [NREQ-1:0] w_ovf;
    logic            w_any;
    logic [IDW-1:0]  w_win_id;
    logic [VW-1:0]   w_sel_a;
    logic [VW-1:0]   w_sel_b;
    logic [TW-1:0]   w_tag;
    logic            w_tag_v;
    logic [IDW-1:0]  w_tag_id;

    logic            r_cp_valid;
    logic [VW-1:0]   r_cp_a;
    logic [VW-1:0]   r_cp_b;
    logic [IDW-1:0]  r_cp_id;
    logic [IDW-1:0]  r_ptr;
    logic [NREQ-1:0] r_rsp_valid;
    logic [VW-1:0]   r_rsp_data;
    logic            r_err;

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_grant)
    );

    assign req_ready = reset_l ? w_grant : '0;
    assign w_acc     = req_ready & req_valid;
    assign w_any     = |w_acc;

    // Per-requester credit counter; a simultaneous grant and return cancel out.
    for (genvar g = 0; g < int'(NREQ); g++) begin : g_cred
        logic [CW-1:0] r_cred;

        assign w_elig[g] = req_valid[g] && (r_cred != '0);
        assign w_ovf[g]  = credit_ret[g] && !w_acc[g] && (r_cred == CW'(MAXCRED));

        always_ff @(posedge clk) begin
            if (!reset_l) begin
                r_cred <= CW'(MAXCRED);
            end else if (w_acc[g] && !credit_ret[g]) begin
                r_cred <= r_cred - CW'(1);
            end else if (credit_ret[g] && !w_acc[g] && (r_cred != CW'(MAXCRED))) begin
                r_cred <= r_cred + CW'(1);
            end
        end
    end

    // Winner encode and operand steering.
    always_comb begin
        w_win_id = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_acc[i]) begin
                w_win_id = IDW'(i);
                w_sel_a  = req_a[i*VW +: VW];
                w_sel_b  = req_b[i*VW +: VW];
            end
        end
    end

    // Issue stage; operands hold on idle cycles.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_cp_valid <= 1'b0;
            r_cp_a     <= '0;
            r_cp_b     <= '0;
            r_cp_id    <= '0;
            r_ptr      <= IDW'(NREQ - 1);
        end else begin
            r_cp_valid <= w_any;
            if (w_any) begin
                r_cp_a  <= w_sel_a;
                r_cp_b  <= w_sel_b;
                r_cp_id <= w_win_id;
                r_ptr   <= w_win_id;
            end
        end
    end

    // Tag enters alongside cp_valid so it emerges in the same cycle as cp_o.
    delay_pipe #(
        .DELAY (LAT),
        .WIDTH (TW)
    ) u_tag (
        .clk     (clk),
        .reset_l (reset_l),
        .i_d     ({r_cp_valid, r_cp_id}),
        .o_q     (w_tag)
    );

    assign w_tag_v  = w_tag[TW-1];
    assign w_tag_id = w_tag[IDW-1:0];

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= w_tag_v ? (NREQ'(1) << w_tag_id) : '0;
            if (w_tag_v) begin
                r_rsp_data <= cp_o;
            end
            r_err <= r_err | (|w_ovf);
        end
    end

    assign cp_valid  = r_cp_valid;
    assign cp_a      = r_cp_a;
    assign cp_b      = r_cp_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign cred_err  = r_err;

endmodule
